// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the ID-stage hazard scoreboard.
package hazard_pkg;

  localparam logic [1:0] CAUSE_NONE   = 2'b00;
  localparam logic [1:0] CAUSE_DATA   = 2'b01;
  localparam logic [1:0] CAUSE_BRANCH = 2'b10;

  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One countdown slice: load on set, else count down to zero.
module sb_entry #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_set,
  input  logic [CNT_W-1:0] i_val,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_cnt <= '0;
    else if (i_set)        r_cnt <= i_val;
    else if (r_cnt != '0)  r_cnt <= r_cnt - CNT_W'(1);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard detector built on per-register writer countdowns,
// with stall cause reporting and a saturating stall-cycle counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int RA_W       = 5,
  parameter int ALU_LAT    = 0,
  parameter int LOAD_LAT   = 1,
  parameter int BR_PENALTY = 1,
  parameter int PERF_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [RA_W-1:0]   id_rs1,
  input  logic [RA_W-1:0]   id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_is_branch,
  input  logic [RA_W-1:0]   id_rd,
  input  logic              id_regwrite,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        stall_cause,
  output logic [PERF_W-1:0] stall_count
);

  localparam int MAXL  = (ALU_LAT > LOAD_LAT) ? ALU_LAT : LOAD_LAT;
  localparam int CW    = clog2(MAXL + BR_PENALTY + 1);
  localparam int CNT_W = (CW < 1) ? 1 : CW;
  localparam int NIDX  = 1 << RA_W;

  localparam logic [CNT_W-1:0] SET_ALU = CNT_W'(ALU_LAT + BR_PENALTY);
  localparam logic [CNT_W-1:0] SET_LD  = CNT_W'(LOAD_LAT + BR_PENALTY);
  localparam logic [CNT_W-1:0] BRP     = CNT_W'(BR_PENALTY);

  logic [CNT_W-1:0] w_cnt [NIDX];
  logic             w_haz1;
  logic             w_haz2;
  logic             w_stall;
  logic             w_issue;
  logic [CNT_W-1:0] w_set_val;
  logic [CNT_W-1:0] w_c1;
  logic [CNT_W-1:0] w_c2;
  logic [PERF_W-1:0] r_stall_count;

  assign w_cnt[0]  = '0;
  assign w_set_val = id_is_load ? SET_LD : SET_ALU;

  // Indices past NUM_REGS decode to an empty slot that never hazards.
  for (genvar r = 1; r < NIDX; r++) begin : g_ent
    if (r < NUM_REGS) begin : g_live
      sb_entry #(.CNT_W(CNT_W)) u_ent (
        .clk   (clk),
        .rst   (rst),
        .i_set (w_issue & id_regwrite & (id_rd == RA_W'(r))),
        .i_val (w_set_val),
        .o_cnt (w_cnt[r])
      );
    end else begin : g_pad
      assign w_cnt[r] = '0;
    end
  end

  assign w_c1 = w_cnt[id_rs1];
  assign w_c2 = w_cnt[id_rs2];

  // Branches compare in ID, so they must wait out the extra penalty.
  assign w_haz1 = id_valid & id_use_rs1 & (id_rs1 != '0) &
                  (id_is_branch ? (w_c1 != '0) : (w_c1 > BRP));
  assign w_haz2 = id_valid & id_use_rs2 & (id_rs2 != '0) &
                  (id_is_branch ? (w_c2 != '0) : (w_c2 > BRP));

  assign w_stall = (w_haz1 | w_haz2) & ~flush;
  assign w_issue = id_valid & ~w_stall & ~flush;

  always_comb begin
    stall_cause = CAUSE_NONE;
    unique case (1'b1)
      w_stall &  id_is_branch: stall_cause = CAUSE_BRANCH;
      w_stall & ~id_is_branch: stall_cause = CAUSE_DATA;
      default:                 stall_cause = CAUSE_NONE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stall_count <= '0;
    else if (w_stall && (r_stall_count != '1))
      r_stall_count <= r_stall_count + PERF_W'(1);
  end

  assign stall       = w_stall;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: default-parameter DUT A and a long-latency,
// narrow-counter DUT B, each driven from its own stimulus word.
module tb_hazard_scoreboard;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       br;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    logic       fl;
  } stim_t;

  typedef struct {
    bit         d;
    bit         st;
    logic [1:0] cause;
    string      tag;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  stim_t sa;
  stim_t sb;

  logic        stall_a, stall_b;
  logic [1:0]  cause_a, cause_b;
  logic [31:0] cnt_a;
  logic [2:0]  cnt_b;

  exp_t expq[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  localparam stim_t IDLE = '0;

  always #5 clk = ~clk;

  hazard_scoreboard u_dut_a (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (sa.v),
    .id_rs1       (sa.rs1),
    .id_rs2       (sa.rs2),
    .id_use_rs1   (sa.u1),
    .id_use_rs2   (sa.u2),
    .id_is_branch (sa.br),
    .id_rd        (sa.rd),
    .id_regwrite  (sa.rw),
    .id_is_load   (sa.ld),
    .flush        (sa.fl),
    .stall        (stall_a),
    .stall_cause  (cause_a),
    .stall_count  (cnt_a)
  );

  hazard_scoreboard #(
    .ALU_LAT    (0),
    .LOAD_LAT   (3),
    .BR_PENALTY (2),
    .PERF_W     (3)
  ) u_dut_b (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (sb.v),
    .id_rs1       (sb.rs1),
    .id_rs2       (sb.rs2),
    .id_use_rs1   (sb.u1),
    .id_use_rs2   (sb.u2),
    .id_is_branch (sb.br),
    .id_rd        (sb.rd),
    .id_regwrite  (sb.rw),
    .id_is_load   (sb.ld),
    .flush        (sb.fl),
    .stall        (stall_b),
    .stall_cause  (cause_b),
    .stall_count  (cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic stim_t alu(input logic [4:0] rd);
    stim_t s = IDLE;
    s.v = 1'b1; s.rd = rd; s.rw = 1'b1;
    return s;
  endfunction

  function automatic stim_t load(input logic [4:0] rd);
    stim_t s = alu(rd);
    s.ld = 1'b1;
    return s;
  endfunction

  function automatic stim_t add(input logic [4:0] rs,
                                input logic [4:0] rd);
    stim_t s = alu(rd);
    s.rs1 = rs; s.u1 = 1'b1;
    return s;
  endfunction

  function automatic stim_t beq(input logic [4:0] a,
                                input logic [4:0] b);
    stim_t s = IDLE;
    s.v = 1'b1; s.br = 1'b1;
    s.rs1 = a; s.rs2 = b; s.u1 = 1'b1; s.u2 = 1'b1;
    return s;
  endfunction

  task automatic step(input bit d, input stim_t s, input bit est,
                      input logic [1:0] ec, input string tag);
    exp_t e;
    if (d) begin sb = s; sa = IDLE; end
    else   begin sa = s; sb = IDLE; end
    expq.push_back('{d, est, ec, tag});
    @(negedge clk);
    e = expq.pop_front();
    if (e.d) begin
      chk({e.tag, "_stall"}, 32'(stall_b), 32'(e.st));
      chk({e.tag, "_cause"}, 32'(cause_b), 32'(e.cause));
    end else begin
      chk({e.tag, "_stall"}, 32'(stall_a), 32'(e.st));
      chk({e.tag, "_cause"}, 32'(cause_a), 32'(e.cause));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    stim_t s;
    sa = IDLE;
    sb = IDLE;
    @(negedge clk);
    chk("rst_stall_a", 32'(stall_a), 32'd0);
    chk("rst_cause_a", 32'(cause_a), 32'd0);
    chk("rst_cnt_a", cnt_a, 32'd0);
    chk("rst_cnt_b", 32'(cnt_b), 32'd0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // ALU -> use: no stall
    step(0, alu(5), 0, 2'b00, "alu_x5");
    step(0, add(5, 10), 0, 2'b00, "alu_use");
    // load -> use: one data stall
    step(0, load(5), 0, 2'b00, "ld_x5");
    step(0, add(5, 11), 1, 2'b01, "lu_st1");
    step(0, add(5, 11), 0, 2'b00, "lu_go");
    chk("cnt_after_lu", cnt_a, 32'd1);
    // load -> branch: two, ALU -> branch: one
    step(0, load(5), 0, 2'b00, "ld_x5b");
    step(0, beq(5, 6), 1, 2'b10, "lb_st1");
    step(0, beq(5, 6), 1, 2'b10, "lb_st2");
    step(0, beq(5, 6), 0, 2'b00, "lb_go");
    step(0, alu(6), 0, 2'b00, "alu_x6");
    step(0, beq(6, 6), 1, 2'b10, "ab_st1");
    step(0, beq(6, 6), 0, 2'b00, "ab_go");
    chk("cnt_after_br", cnt_a, 32'd4);
    // x0 never tracked
    step(0, load(0), 0, 2'b00, "ld_x0");
    step(0, beq(0, 0), 0, 2'b00, "use_x0");
    // flush suppresses stall and issue
    step(0, load(7), 0, 2'b00, "ld_x7");
    s = add(7, 8);
    s.fl = 1'b1;
    step(0, s, 0, 2'b00, "flush_use");
    step(0, beq(8, 8), 0, 2'b00, "no_set_x8");
    chk("cnt_after_fl", cnt_a, 32'd4);

    // reset in the middle of a branch stall
    step(0, load(5), 0, 2'b00, "ld_x5c");
    sa = beq(5, 6);
    @(negedge clk);
    chk("pre_rst_stall", 32'(stall_a), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_stall", 32'(stall_a), 32'd0);
    chk("mid_rst_cause", 32'(cause_a), 32'd0);
    chk("mid_rst_cnt", cnt_a, 32'd0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    step(0, add(5, 12), 0, 2'b00, "post_rst");

    // long-latency build: 3 data stalls, 5 branch stalls
    step(1, load(9), 0, 2'b00, "b_ld9");
    for (int i = 0; i < 3; i++)
      step(1, add(9, 10), 1, 2'b01, "b_lu_st");
    step(1, add(9, 10), 0, 2'b00, "b_lu_go");
    chk("b_cnt3", 32'(cnt_b), 32'd3);
    step(1, load(9), 0, 2'b00, "b_ld9b");
    for (int i = 0; i < 5; i++)
      step(1, beq(9, 1), 1, 2'b10, "b_lb_st");
    step(1, beq(9, 1), 0, 2'b00, "b_lb_go");
    chk("b_cnt_sat", 32'(cnt_b), 32'd7);
    // WAW: newer ALU writer shortens the wait
    step(1, load(9), 0, 2'b00, "b_ld9c");
    step(1, alu(9), 0, 2'b00, "b_alu9");
    step(1, add(9, 11), 0, 2'b00, "b_waw_use");
    // still saturated after more stalls
    step(1, load(13), 0, 2'b00, "b_ld13");
    step(1, add(13, 14), 1, 2'b01, "b_sat_st");
    step(1, add(13, 14), 1, 2'b01, "b_sat_st2");
    chk("b_cnt_hold", 32'(cnt_b), 32'd7);

    sa = IDLE;
    sb = IDLE;
    if (expq.size() != 0)
      chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
